// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared timing constants, totals and coordinate type for the VGA raster generator
package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return visible + front + sync + back;
   endfunction

   function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster coordinate and sync bundle from the timing generator to pixel stages
interface vga_timing_if;
   import vga_timing_pkg::*;

   coord_t      DrawX;
   coord_t      DrawY;
   logic        blank;
   logic        hs;
   logic        vs;
   logic        vblank_start;
   logic [15:0] frame_count;

   modport master (output DrawX, DrawY, blank, hs, vs, vblank_start, frame_count);
   modport slave  (input  DrawX, DrawY, blank, hs, vs, vblank_start, frame_count);

endinterface

// File: rtl/vga_timing_axis.sv
// rtl/vga_timing_axis.sv - one raster axis: wrapping counter with registered active and sync_n
module vga_timing_axis
   import vga_timing_pkg::*;
#(
   parameter int unsigned VISIBLE = 640,
   parameter int unsigned FRONT   = 16,
   parameter int unsigned SYNC    = 96,
   parameter int unsigned BACK    = 48
) (
   input  logic   vga_clk,
   input  logic   reset_n,
   input  logic   en,
   output logic   wrap,
   output coord_t count_next,
   output coord_t count,
   output logic   active,
   output logic   sync_n
);

   localparam int unsigned TOTAL   = h_total(VISIBLE, FRONT, SYNC, BACK);
   localparam coord_t      LAST    = coord_t'(TOTAL - 1);
   localparam coord_t      VIS_END = coord_t'(VISIBLE);
   localparam coord_t      SYNC_LO = coord_t'(VISIBLE + FRONT);
   localparam coord_t      SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC);

   always_comb begin
      wrap       = en && (count == LAST);
      count_next = count;
      if (en) begin
         count_next = wrap ? '0 : count + coord_t'(1);
      end
   end

   // active/sync_n are derived from count_next so they line up with count in every cycle
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         count  <= '0;
         active <= 1'b1;
         sync_n <= 1'b1;
      end else begin
         count  <= count_next;
         active <= (count_next < VIS_END);
         sync_n <= !((count_next >= SYNC_LO) && (count_next < SYNC_HI));
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing: coordinates, blank, syncs and per-frame tick
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF
) (
   input  logic         vga_clk,
   input  logic         reset_n,
   vga_timing_if.master vid
);

   localparam coord_t VBLANK_LINE = coord_t'(V_VISIBLE);

   coord_t      h_count, h_next, v_count, v_next;
   logic        h_wrap, v_wrap_unused;
   logic        h_active, v_active, h_sync_n, v_sync_n;
   logic        vblank_q;
   logic [15:0] frame_count_q;

   vga_timing_axis #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_axis (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .en         (1'b1),
      .wrap       (h_wrap),
      .count_next (h_next),
      .count      (h_count),
      .active     (h_active),
      .sync_n     (h_sync_n)
   );

   vga_timing_axis #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_axis (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .en         (h_wrap),
      .wrap       (v_wrap_unused),
      .count_next (v_next),
      .count      (v_count),
      .active     (v_active),
      .sync_n     (v_sync_n)
   );

   // frame tick marks entry into vertical blanking, not the start of line 0
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         vblank_q      <= 1'b0;
         frame_count_q <= '0;
      end else begin
         vblank_q <= (h_next == '0) && (v_next == VBLANK_LINE);
         if ((h_next == '0) && (v_next == VBLANK_LINE)) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   assign vid.DrawX        = h_count;
   assign vid.DrawY        = v_count;
   assign vid.blank        = h_active & v_active;
   assign vid.hs           = h_sync_n;
   assign vid.vs           = v_sync_n;
   assign vid.vblank_start = vblank_q;
   assign vid.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default-timing line checks plus a reduced-timing instance for frame-level checks
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   // reduced raster: 16 x 13, frame = 208 cycles, vblank at line 6, hs low x 10..12, vs low y 8..9
   localparam int S_HTOT  = 16;
   localparam int S_VTOT  = 13;
   localparam int S_FRAME = 208;

   logic vga_clk   = 1'b0;
   logic reset_n   = 1'b0;
   logic reset_s_n = 1'b0;
   int   checks    = 0;
   int   errors    = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_if vid_d ();
   vga_timing_if vid_s ();

   vga_timing_gen dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vid     (vid_d)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_s (
      .vga_clk (vga_clk),
      .reset_n (reset_s_n),
      .vid     (vid_s)
   );

   task automatic tick;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      reset_s_n = 1'b0;
      repeat (5) tick();
      checks++; if (vid_d.DrawX !== 10'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", vid_d.DrawX); end
      checks++; if (vid_d.DrawY !== 10'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", vid_d.DrawY); end
      checks++; if (vid_d.blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", vid_d.blank); end
      checks++; if (vid_d.hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", vid_d.hs); end
      checks++; if (vid_d.vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", vid_d.vs); end
      checks++; if (vid_d.vblank_start !== 1'b0) begin errors++; $display("FAIL reset_vblank got %b exp 0", vid_d.vblank_start); end
      checks++; if (vid_d.frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d exp 0", vid_d.frame_count); end
      reset_n = 1'b1;
      tick();
      checks++; if (vid_d.DrawX !== 10'd1) begin errors++; $display("FAIL release_x got %0d exp 1", vid_d.DrawX); end
      checks++; if (vid_d.DrawY !== 10'd0) begin errors++; $display("FAIL release_y got %0d exp 0", vid_d.DrawY); end
   endtask

   task automatic test_hline;
      int hs_low;
      hs_low = 0;
      for (int i = 0; i < 1000 && vid_d.DrawX !== 10'd0; i++) tick();
      checks++; if (vid_d.DrawX !== 10'd0) begin errors++; $display("FAIL hline_start got %0d exp 0", vid_d.DrawX); end
      for (int x = 0; x < 800; x++) begin
         checks++; if (vid_d.DrawX !== 10'(x)) begin errors++; $display("FAIL hline_x got %0d exp %0d", vid_d.DrawX, x); end
         checks++; if (vid_d.DrawY !== 10'd1) begin errors++; $display("FAIL hline_y got %0d exp 1", vid_d.DrawY); end
         checks++; if (vid_d.blank !== (x < 640)) begin errors++; $display("FAIL hline_blank x=%0d got %b exp %b", x, vid_d.blank, (x < 640)); end
         checks++; if (vid_d.hs !== !(x >= 656 && x < 752)) begin errors++; $display("FAIL hline_hs x=%0d got %b exp %b", x, vid_d.hs, !(x >= 656 && x < 752)); end
         if (vid_d.hs === 1'b0) hs_low++;
         tick();
      end
      checks++; if (hs_low !== 96) begin errors++; $display("FAIL hline_hs_width got %0d exp 96", hs_low); end
      checks++; if (vid_d.DrawX !== 10'd0 || vid_d.DrawY !== 10'd2) begin
         errors++; $display("FAIL hline_wrap got (%0d,%0d) exp (0,2)", vid_d.DrawX, vid_d.DrawY); end
   endtask

   task automatic test_hsync_reset;
      for (int i = 0; i < 1000 && vid_d.DrawX !== 10'd700; i++) tick();
      checks++; if (vid_d.hs !== 1'b0) begin errors++; $display("FAIL hrst_pre_hs got %b exp 0", vid_d.hs); end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++; if (vid_d.hs !== 1'b1) begin errors++; $display("FAIL hrst_hs got %b exp 1", vid_d.hs); end
      checks++; if (vid_d.DrawX !== 10'd0 || vid_d.DrawY !== 10'd0) begin
         errors++; $display("FAIL hrst_xy got (%0d,%0d) exp (0,0)", vid_d.DrawX, vid_d.DrawY); end
      for (int x = 1; x < 800; x++) begin
         tick();
         checks++; if (vid_d.DrawX !== 10'(x) || vid_d.hs !== !(x >= 656 && x < 752)) begin
            errors++; $display("FAIL hrst_resume x=%0d got x=%0d hs=%b", x, vid_d.DrawX, vid_d.hs); end
      end
   endtask

   task automatic test_frame;
      int x, y, fc, pulses, vs_low;
      int pcyc[3];
      pulses = 0;
      vs_low = 0;
      pcyc   = '{0, 0, 0};
      reset_s_n = 1'b1;
      for (int c = 0; c <= 3 * S_FRAME; c++) begin
         x  = c % S_HTOT;
         y  = (c / S_HTOT) % S_VTOT;
         fc = (c >= 96) ? ((c - 96) / S_FRAME + 1) : 0;
         checks++; if (vid_s.DrawX !== 10'(x) || vid_s.DrawY !== 10'(y)) begin
            errors++; $display("FAIL frame_xy c=%0d got (%0d,%0d) exp (%0d,%0d)", c, vid_s.DrawX, vid_s.DrawY, x, y); end
         checks++; if (vid_s.blank !== (x < 8 && y < 6)) begin
            errors++; $display("FAIL frame_blank c=%0d got %b exp %b", c, vid_s.blank, (x < 8 && y < 6)); end
         checks++; if (vid_s.hs !== !(x >= 10 && x < 13) || vid_s.vs !== !(y >= 8 && y < 10)) begin
            errors++; $display("FAIL frame_sync c=%0d got hs=%b vs=%b", c, vid_s.hs, vid_s.vs); end
         checks++; if (vid_s.vblank_start !== (x == 0 && y == 6)) begin
            errors++; $display("FAIL frame_vblank c=%0d got %b exp %b", c, vid_s.vblank_start, (x == 0 && y == 6)); end
         checks++; if (vid_s.frame_count !== 16'(fc)) begin
            errors++; $display("FAIL frame_fc c=%0d got %0d exp %0d", c, vid_s.frame_count, fc); end
         if (c < S_FRAME && vid_s.vs === 1'b0) vs_low++;
         if (vid_s.vblank_start === 1'b1) begin
            if (pulses < 3) pcyc[pulses] = c;
            pulses++;
         end
         if (c < 3 * S_FRAME) tick();
      end
      checks++; if (pulses !== 3) begin errors++; $display("FAIL frame_pulses got %0d exp 3", pulses); end
      checks++; if (pcyc[0] !== 96) begin errors++; $display("FAIL frame_first_pulse got %0d exp 96", pcyc[0]); end
      checks++; if (pcyc[1] - pcyc[0] !== S_FRAME || pcyc[2] - pcyc[1] !== S_FRAME) begin
         errors++; $display("FAIL frame_period got %0d,%0d exp %0d", pcyc[1] - pcyc[0], pcyc[2] - pcyc[1], S_FRAME); end
      checks++; if (vs_low !== 32) begin errors++; $display("FAIL frame_vs_width got %0d exp 32", vs_low); end
   endtask

   task automatic test_wrap;
      dut_s.frame_count_q = 16'hFFFF;
      tick();
      checks++; if (vid_s.frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", vid_s.frame_count); end
      for (int i = 0; i < 300 && vid_s.vblank_start !== 1'b1; i++) tick();
      checks++; if (vid_s.vblank_start !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp 1", vid_s.vblank_start); end
      checks++; if (vid_s.frame_count !== 16'd0) begin errors++; $display("FAIL wrap_fc got %h exp 0000", vid_s.frame_count); end
      checks++; if (vid_s.DrawX !== 10'd0 || vid_s.DrawY !== 10'd6) begin
         errors++; $display("FAIL wrap_xy got (%0d,%0d) exp (0,6)", vid_s.DrawX, vid_s.DrawY); end
   endtask

   task automatic test_mid_sync_reset;
      int x, y;
      for (int i = 0; i < 300 && !(vid_s.DrawX === 10'd11 && vid_s.DrawY === 10'd9); i++) tick();
      checks++; if (vid_s.hs !== 1'b0 || vid_s.vs !== 1'b0) begin
         errors++; $display("FAIL msr_pre got hs=%b vs=%b exp 0 0", vid_s.hs, vid_s.vs); end
      reset_s_n = 1'b0;
      tick();
      reset_s_n = 1'b1;
      checks++; if (vid_s.hs !== 1'b1 || vid_s.vs !== 1'b1) begin
         errors++; $display("FAIL msr_sync got hs=%b vs=%b exp 1 1", vid_s.hs, vid_s.vs); end
      checks++; if (vid_s.DrawX !== 10'd0 || vid_s.DrawY !== 10'd0) begin
         errors++; $display("FAIL msr_xy got (%0d,%0d) exp (0,0)", vid_s.DrawX, vid_s.DrawY); end
      checks++; if (vid_s.frame_count !== 16'd0 || vid_s.vblank_start !== 1'b0 || vid_s.blank !== 1'b1) begin
         errors++; $display("FAIL msr_state got fc=%0d vb=%b blank=%b exp 0 0 1", vid_s.frame_count, vid_s.vblank_start, vid_s.blank); end
      for (int c = 1; c <= S_FRAME; c++) begin
         tick();
         x = c % S_HTOT;
         y = (c / S_HTOT) % S_VTOT;
         checks++; if (vid_s.DrawX !== 10'(x) || vid_s.DrawY !== 10'(y) ||
                       vid_s.hs !== !(x >= 10 && x < 13) || vid_s.vs !== !(y >= 8 && y < 10)) begin
            errors++; $display("FAIL msr_resume c=%0d got (%0d,%0d) hs=%b vs=%b", c, vid_s.DrawX, vid_s.DrawY, vid_s.hs, vid_s.vs); end
      end
   endtask

   initial begin
      test_reset();
      test_hline();
      test_hsync_reset();
      test_frame();
      test_wrap();
      test_mid_sync_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
